// File: rtl/ccff_chain_programmer.sv
// Serializes bitstream words onto a configuration-flop chain and optionally
// replays the stream to compare the chain tail against what was loaded.
//
// state    | meaning
// ---------+----------------------------------------------------------------
// S_IDLE   | waiting for start after reset
// S_LOAD   | consuming N_WORDS words, shifting CHAIN_LEN bits into the chain
// S_VERIFY | replaying the stream, comparing ccff_tail with ccff_head
// S_DONE   | pass sequence complete; waiting for the next start
module ccff_chain_programmer #(
  parameter int CHAIN_LEN = 6,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              verify_en,
  input  logic [WORD_W-1:0] bs_data,
  input  logic              bs_valid,
  output logic              bs_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int N_WORDS   = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int BIT_W     = $clog2(CHAIN_LEN + 1);
  localparam int WC_W      = $clog2(N_WORDS + 1);
  localparam int VB_W      = $clog2(WORD_W + 1);
  localparam int LAST_BITS = CHAIN_LEN - (N_WORDS - 1) * WORD_W;

  localparam logic [VB_W-1:0]  FULL_CNT     = VB_W'(WORD_W);
  localparam logic [VB_W-1:0]  LAST_CNT     = VB_W'(LAST_BITS);
  localparam logic [VB_W-1:0]  ONE_BIT      = VB_W'(1);
  localparam logic [BIT_W-1:0] LAST_BIT_IDX = BIT_W'(CHAIN_LEN - 1);
  localparam logic [WC_W-1:0]  WORDS        = WC_W'(N_WORDS);
  localparam logic [WC_W-1:0]  LAST_WORD    = WC_W'(N_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_VERIFY = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t             state_q,    state_d;
  logic [WORD_W-1:0]  sreg_q,     sreg_d;
  logic [VB_W-1:0]    vbits_q,    vbits_d;
  logic [BIT_W-1:0]   bit_cnt_q,  bit_cnt_d;
  logic [WC_W-1:0]    word_cnt_q, word_cnt_d;
  logic               verify_q,   verify_d;
  logic               error_q,    error_d;

  logic active;
  logic shift;
  logic ready;
  logic accept;

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state_q    <= S_IDLE;
      sreg_q     <= '0;
      vbits_q    <= '0;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      verify_q   <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      sreg_q     <= sreg_d;
      vbits_q    <= vbits_d;
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
      verify_q   <= verify_d;
      error_q    <= error_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sreg_d     = sreg_q;
    vbits_d    = vbits_q;
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    verify_d   = verify_q;
    error_d    = error_q;

    active = (state_q == S_LOAD) || (state_q == S_VERIFY);
    shift  = active && (vbits_q != '0);
    // Refill while the final held bit is still shifting so words stream with no bubble.
    ready  = active && (word_cnt_q < WORDS) &&
             ((vbits_q == '0) || ((vbits_q == ONE_BIT) && shift));
    accept = bs_valid && ready;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d    = S_LOAD;
          sreg_d     = '0;
          vbits_d    = '0;
          bit_cnt_d  = '0;
          word_cnt_d = '0;
          verify_d   = verify_en;
          error_d    = 1'b0;
        end
      end
      S_LOAD, S_VERIFY: begin
        if (shift) begin
          sreg_d    = sreg_q >> 1;
          vbits_d   = vbits_q - ONE_BIT;
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
          if ((state_q == S_VERIFY) && (ccff_tail != sreg_q[0])) begin
            error_d = 1'b1;
          end
        end
        if (accept) begin
          sreg_d     = bs_data;
          vbits_d    = (word_cnt_q == LAST_WORD) ? LAST_CNT : FULL_CNT;
          word_cnt_d = word_cnt_q + WC_W'(1);
        end
        // Final shift of the pass; clearing sreg drops the unused top bits of the last word.
        if (shift && (bit_cnt_q == LAST_BIT_IDX)) begin
          state_d    = ((state_q == S_LOAD) && verify_q) ? S_VERIFY : S_DONE;
          sreg_d     = '0;
          vbits_d    = '0;
          bit_cnt_d  = '0;
          word_cnt_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bs_ready      = ready;
  assign ccff_head     = sreg_q[0];
  assign ccff_shift_en = shift;
  assign busy          = active;
  assign done          = (state_q == S_DONE);
  assign error         = error_q;

endmodule

// File: tb/tb_ccff_chain_programmer.sv
// Scoreboarded bench: dut_a is a 6-flop chain with 8-bit words, dut_b a 20-flop chain.
module tb_ccff_chain_programmer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic       a_start, a_verify, a_valid, a_ready, a_head, a_shift, a_tail, a_busy, a_done, a_error;
  logic [7:0] a_data;
  logic       b_start, b_verify, b_valid, b_ready, b_head, b_shift, b_tail, b_busy, b_done, b_error;
  logic [7:0] b_data;

  logic [5:0]  chain_a = '0;
  logic [19:0] chain_b = '0;
  logic        a_stuck = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int a_shifts = 0, b_shifts = 0, a_hs = 0, b_hs = 0;
  bit qa[$];
  bit qb[$];
  int a_scyc[$];

  ccff_chain_programmer #(.CHAIN_LEN(6), .WORD_W(8)) dut_a (
    .prog_clk(clk), .pReset(rst), .start(a_start), .verify_en(a_verify),
    .bs_data(a_data), .bs_valid(a_valid), .bs_ready(a_ready),
    .ccff_head(a_head), .ccff_shift_en(a_shift), .ccff_tail(a_tail),
    .busy(a_busy), .done(a_done), .error(a_error));

  ccff_chain_programmer #(.CHAIN_LEN(20), .WORD_W(8)) dut_b (
    .prog_clk(clk), .pReset(rst), .start(b_start), .verify_en(b_verify),
    .bs_data(b_data), .bs_valid(b_valid), .bs_ready(b_ready),
    .ccff_head(b_head), .ccff_shift_en(b_shift), .ccff_tail(b_tail),
    .busy(b_busy), .done(b_done), .error(b_error));

  // Chain models: flop 0 is the tail, the head enters at the top.
  assign a_tail = a_stuck ? 1'b0 : chain_a[0];
  assign b_tail = chain_b[0];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (a_shift) chain_a <= {a_head, chain_a[5:1]};
    if (b_shift) chain_b <= {b_head, chain_b[19:1]};
  end

  always @(negedge clk) begin : mon_a
    bit e;
    if (a_valid && a_ready) a_hs++;
    if (a_shift) begin
      a_shifts++;
      a_scyc.push_back(cyc);
      checks++;
      if (qa.size() == 0) begin
        errors++;
        $display("FAIL a_unexpected_shift: shift_en=1 at cycle %0d, required no shift", cyc);
      end else begin
        e = qa.pop_front();
        if (a_head !== e) begin
          errors++;
          $display("FAIL a_head_bit: cycle %0d got %b, required %b", cyc, a_head, e);
        end
      end
    end
  end

  always @(negedge clk) begin : mon_b
    bit e;
    if (b_valid && b_ready) b_hs++;
    if (b_shift) begin
      b_shifts++;
      checks++;
      if (qb.size() == 0) begin
        errors++;
        $display("FAIL b_unexpected_shift: shift_en=1 at cycle %0d, required no shift", cyc);
      end else begin
        e = qb.pop_front();
        if (b_head !== e) begin
          errors++;
          $display("FAIL b_head_bit: cycle %0d got %b, required %b", cyc, b_head, e);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic start_a(input logic ve);
    a_start = 1'b1; a_verify = ve;
    @(posedge clk); #1;
    a_start = 1'b0; a_verify = 1'b0;
    checks++;
    if (a_busy !== 1'b1 || a_ready !== 1'b1) begin
      errors++;
      $display("FAIL a_start_latency: busy=%b ready=%b, required 1 1", a_busy, a_ready);
    end
  endtask

  task automatic start_b(input logic ve);
    b_start = 1'b1; b_verify = ve;
    @(posedge clk); #1;
    b_start = 1'b0; b_verify = 1'b0;
    checks++;
    if (b_busy !== 1'b1 || b_ready !== 1'b1) begin
      errors++;
      $display("FAIL b_start_latency: busy=%b ready=%b, required 1 1", b_busy, b_ready);
    end
  endtask

  task automatic send_a(input logic [7:0] d, input int nbits);
    int n = 0;
    for (int i = 0; i < nbits; i++) qa.push_back(d[i]);
    a_data = d; a_valid = 1'b1;
    @(negedge clk);
    while (!a_ready && n < 64) begin @(negedge clk); n++; end
    if (!a_ready) begin
      checks++; errors++;
      $display("FAIL a_handshake_timeout: ready=%b after %0d cycles, required 1", a_ready, n);
      a_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    a_valid = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] d, input int nbits);
    int n = 0;
    for (int i = 0; i < nbits; i++) qb.push_back(d[i]);
    b_data = d; b_valid = 1'b1;
    @(negedge clk);
    while (!b_ready && n < 64) begin @(negedge clk); n++; end
    if (!b_ready) begin
      checks++; errors++;
      $display("FAIL b_handshake_timeout: ready=%b after %0d cycles, required 1", b_ready, n);
      b_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    b_valid = 1'b0;
  endtask

  task automatic wait_done_a(output int dc);
    int n = 0;
    @(negedge clk);
    while (!a_done && n < 100) begin @(negedge clk); n++; end
    dc = cyc;
    if (!a_done) begin
      checks++; errors++;
      $display("FAIL a_done_timeout: done=%b after %0d cycles, required 1", a_done, n);
    end
  endtask

  task automatic wait_done_b();
    int n = 0;
    @(negedge clk);
    while (!b_done && n < 200) begin @(negedge clk); n++; end
    if (!b_done) begin
      checks++; errors++;
      $display("FAIL b_done_timeout: done=%b after %0d cycles, required 1", b_done, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({a_ready, a_head, a_shift, a_busy, a_done, a_error} !== 6'b0) begin
      errors++;
      $display("FAIL reset_a_outputs: got %b, required 000000",
               {a_ready, a_head, a_shift, a_busy, a_done, a_error});
    end
    checks++;
    if ({b_ready, b_head, b_shift, b_busy, b_done, b_error} !== 6'b0) begin
      errors++;
      $display("FAIL reset_b_outputs: got %b, required 000000",
               {b_ready, b_head, b_shift, b_busy, b_done, b_error});
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_load_only();
    int base, dc;
    base = a_shifts; a_scyc.delete();
    start_a(1'b0);
    send_a(8'h2D, 6);
    wait_done_a(dc);
    checks++;
    if (a_shifts - base != 6) begin
      errors++; $display("FAIL load_shift_count: got %0d, required 6", a_shifts - base);
    end
    checks++;
    if (a_scyc.size() != 6 || a_scyc[5] - a_scyc[0] != 5) begin
      errors++; $display("FAIL load_consecutive: %0d shifts, not in 6 consecutive cycles", a_scyc.size());
    end
    checks++;
    if (chain_a !== 6'h2D) begin
      errors++; $display("FAIL load_chain_contents: got %h, required 2d", chain_a);
    end
    checks++;
    if (a_done !== 1'b1 || a_error !== 1'b0 || a_busy !== 1'b0) begin
      errors++; $display("FAIL load_status: done=%b error=%b busy=%b, required 1 0 0", a_done, a_error, a_busy);
    end
    checks++;
    if (a_scyc.size() == 0 || dc != a_scyc[a_scyc.size()-1] + 1) begin
      errors++; $display("FAIL load_done_timing: done at cycle %0d, required one after last shift", dc);
    end
  endtask

  task automatic test_verify_good();
    int base, dc;
    base = a_shifts; a_scyc.delete();
    start_a(1'b1);
    send_a(8'h2D, 6);
    send_a(8'h2D, 6);
    wait_done_a(dc);
    checks++;
    if (a_shifts - base != 12) begin
      errors++; $display("FAIL verify_shift_count: got %0d, required 12", a_shifts - base);
    end
    checks++;
    if (a_scyc.size() != 12 || a_scyc[6] - a_scyc[5] != 2 || a_scyc[11] - a_scyc[0] != 12) begin
      errors++; $display("FAIL verify_one_bubble: %0d shifts, pass gap not exactly one cycle", a_scyc.size());
    end
    checks++;
    if (a_done !== 1'b1 || a_error !== 1'b0) begin
      errors++; $display("FAIL verify_good_status: done=%b error=%b, required 1 0", a_done, a_error);
    end
  endtask

  task automatic test_stuck_tail();
    int dc;
    a_stuck = 1'b1;
    start_a(1'b1);
    send_a(8'h2D, 6);
    send_a(8'h2D, 6);
    checks++;
    if (a_error !== 1'b0) begin
      errors++; $display("FAIL stuck_error_early: got %b before first replay shift, required 0", a_error);
    end
    @(posedge clk); #1;
    checks++;
    if (a_error !== 1'b1) begin
      errors++; $display("FAIL stuck_error_index0: got %b, required 1", a_error);
    end
    wait_done_a(dc);
    checks++;
    if (a_error !== 1'b1 || a_done !== 1'b1) begin
      errors++; $display("FAIL stuck_error_sticky: error=%b done=%b, required 1 1", a_error, a_done);
    end
    a_stuck = 1'b0;
    start_a(1'b0);
    checks++;
    if (a_error !== 1'b0) begin
      errors++; $display("FAIL stuck_error_clear: got %b after start, required 0", a_error);
    end
    send_a(8'h2D, 6);
    wait_done_a(dc);
  endtask

  task automatic test_multiword_backpressure();
    logic [7:0] words [3];
    words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'hFF;
    b_hs = 0; b_shifts = 0;
    start_b(1'b0);
    for (int w = 0; w < 3; w++) begin
      send_b(words[w], (w == 2) ? 4 : 8);
      if (w < 2) begin
        int n = 0;
        @(negedge clk);
        while (!b_ready && n < 32) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        for (int g = 0; g < 3; g++) begin
          @(negedge clk);
          checks++;
          if (b_shift !== 1'b0) begin
            errors++; $display("FAIL gap_shift_en: word %0d gap %0d got %b, required 0", w, g, b_shift);
          end
        end
        @(posedge clk); #1;
      end
    end
    checks++;
    if (b_ready !== 1'b0) begin
      errors++; $display("FAIL last_word_ready: got %b, required 0", b_ready);
    end
    wait_done_b();
    checks++;
    if (b_hs != 3 || b_shifts != 20) begin
      errors++; $display("FAIL multi_counts: handshakes=%0d shifts=%0d, required 3 20", b_hs, b_shifts);
    end
    checks++;
    if (chain_b !== 20'hF3CA5) begin
      errors++; $display("FAIL multi_chain_contents: got %h, required f3ca5", chain_b);
    end
    checks++;
    if (qb.size() != 0) begin
      errors++; $display("FAIL multi_bits_left: %0d expected bits never shifted, required 0", qb.size());
    end
  endtask

  task automatic test_reset_mid_load();
    int base, dc;
    start_a(1'b0);
    send_a(8'h2D, 6);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1; a_start = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({a_ready, a_head, a_shift, a_busy, a_done, a_error} !== 6'b0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got %b, required 000000",
               {a_ready, a_head, a_shift, a_busy, a_done, a_error});
    end
    rst = 1'b0; a_start = 1'b0;
    qa.delete();
    @(posedge clk); #1;
    base = a_shifts;
    start_a(1'b0);
    send_a(8'h2D, 6);
    wait_done_a(dc);
    checks++;
    if (a_shifts - base != 6 || chain_a !== 6'h2D) begin
      errors++; $display("FAIL mid_reset_reload: shifts=%0d chain=%h, required 6 2d", a_shifts - base, chain_a);
    end
  endtask

  task automatic test_start_while_busy();
    int base, dc;
    base = a_shifts;
    start_a(1'b0);
    a_start = 1'b1; a_verify = 1'b1;
    send_a(8'h2D, 6);
    repeat (2) @(posedge clk);
    #1;
    a_start = 1'b0; a_verify = 1'b0;
    wait_done_a(dc);
    repeat (3) @(negedge clk);
    checks++;
    if (a_shifts - base != 6) begin
      errors++; $display("FAIL busy_start_shifts: got %0d, required 6", a_shifts - base);
    end
    checks++;
    if (a_done !== 1'b1 || a_busy !== 1'b0 || a_ready !== 1'b0) begin
      errors++; $display("FAIL busy_start_hold: done=%b busy=%b ready=%b, required 1 0 0", a_done, a_busy, a_ready);
    end
  endtask

  initial begin
    rst = 1'b1;
    a_start = 1'b0; a_verify = 1'b0; a_valid = 1'b0; a_data = '0;
    b_start = 1'b0; b_verify = 1'b0; b_valid = 1'b0; b_data = '0;
    test_reset();
    test_load_only();
    test_verify_good();
    test_stuck_tail();
    test_multiword_backpressure();
    test_reset_mid_load();
    test_start_while_busy();
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ccff_chain_programmer.md
# ccff_chain_programmer

Configuration-chain driver for the routing fabric. It takes bitstream words over a valid/ready handshake and serializes them onto `ccff_head` of a configuration-flop chain, such as the `ccff_head` → `ccff_tail` chain through a connection block's mux memories. It can optionally replay the bitstream and compare it against `ccff_tail` to prove that the chain loaded correctly. It sits between the bitstream source (a test-bench loader or an on-chip config controller) and the head of the chain.

## Interface
Parameters:
- `CHAIN_LEN`, default 6: number of flops in the attached chain (≥1).
- `WORD_W`, default 8: width of a bitstream word (≥1).
- `N_WORDS`, derived as ceil(CHAIN_LEN/WORD_W): words consumed per pass.

Ports:
- `prog_clk` input 1: clock. Shared with the chain; the chain shifts on `prog_clk` edges gated by `ccff_shift_en`.
- `pReset` input 1: reset, synchronous and active-high.
- `start` input 1: one-cycle pulse that begins a sequence; sampled in IDLE/DONE only.
- `verify_en` input 1: sampled with `start`; 1 = run a LOAD pass then a VERIFY pass.
- `bs_data` input WORD_W: bitstream word; bit 0 is shifted first.
- `bs_valid` input 1: `bs_data` is valid.
- `bs_ready` output 1: word accepted when `bs_valid && bs_ready`.
- `ccff_head` output 1: serial data into the chain head.
- `ccff_shift_en` output 1: chain advances on the next `prog_clk` edge.
- `ccff_tail` input 1: serial data from the chain tail.
- `busy` output 1: high in LOAD or VERIFY.
- `done` output 1: high in DONE.
- `error` output 1: sticky verify mismatch flag.

## Operation
States:
- **IDLE**
  - `start` → LOAD; clears `error` and the counters; latches `verify_en`.
- **LOAD**
  - Consumes N_WORDS words and shifts exactly CHAIN_LEN bits.
  - Bits of the last word beyond CHAIN_LEN are discarded. Example: CHAIN_LEN=20, WORD_W=8 gives 3 words, and bits 4..7 of word 2 are dropped.
  - When the bit count reaches CHAIN_LEN: go to VERIFY if `verify_en` was latched, else DONE.
- **VERIFY**
  - The source replays the identical bitstream, consumed and shifted exactly as in LOAD.
  - In every cycle with `ccff_shift_en`=1, compare `ccff_tail` with `ccff_head`. For a chain of exactly CHAIN_LEN flops, the tail bit at replay index i equals LOAD bit i.
  - Any mismatch sets `error`, which holds until the next `start`.
  - Go to DONE after CHAIN_LEN shifts.
- **DONE**
  - `done`=1.
  - `start` → LOAD with the same clearing as from IDLE; otherwise hold.

Serializer:
- Holding register loaded on handshake; remaining-bit counter per word.
- `ccff_head` = current LSB of the register.
- `ccff_shift_en`=1 only in LOAD/VERIFY cycles where a valid bit is held. An empty register is a bubble: `ccff_shift_en`=0 and the chain holds.
- `bs_ready`=1 in LOAD/VERIFY when words remain in the pass AND (the register is empty OR its last valid bit is shifting this cycle). This gives back-to-back words with no bubble.
- `bs_ready`=0 in IDLE and DONE, and after the last word of a pass is accepted.
- Handshakes outside LOAD/VERIFY are impossible; `bs_data` is ignored.
- Bit counter width: clog2(CHAIN_LEN+1). Word counter width: clog2(N_WORDS+1). Neither wraps: the counters stop the pass exactly.
- `start` while busy is ignored.
- `bs_valid` dropping mid-pass stalls the pass indefinitely; there is no timeout.

## Timing
- Reset values: state IDLE; `bs_ready`=0, `ccff_head`=0, `ccff_shift_en`=0, `busy`=0, `done`=0, `error`=0; counters 0.
- `pReset` asserted mid-operation returns the block to IDLE on the next edge with the above values.
  - The chain contents are undefined afterwards; a new `start` is required.
  - `pReset` overrides `start` in the same cycle.
- Latency:
  - `start` at edge t: `busy`=1 and `bs_ready`=1 from cycle t+1.
  - Word accepted at edge k: first bit on `ccff_head` with `ccff_shift_en`=1 in cycle k+1.
  - With `bs_valid` held high, a pass takes N_WORDS-independent CHAIN_LEN shift cycles plus 1 initial cycle.
- Pass boundary:
  - The last LOAD shift edge moves the state to VERIFY/DONE.
  - VERIFY `bs_ready` rises in the following cycle: one bubble between passes.
- `error` updates at the edge of the mismatching shift and is visible the following cycle.
- `done` rises the cycle after the final shift.

## Test plan
- **Load only.** CHAIN_LEN=6, WORD_W=8, `verify_en`=0, word 0x2D. Required:
  - `ccff_head` sequence 1,0,1,1,0,1 on 6 consecutive `ccff_shift_en` cycles.
  - A 6-flop chain model holds 0x2D[5:0].
  - `done`=1 and `error`=0.
- **Load plus verify, good chain.** Same word sent twice. Required: 12 shift cycles, one bubble between passes, `error`=0, `done`=1.
- **Stuck tail.** Tail forced to 0, word 0x2D, verify. Required: `error` set after replay index 0 (expected 1, got 0); stays 1 through DONE; cleared by the next `start`.
- **Multi-word with backpressure.** CHAIN_LEN=20, WORD_W=8, words 0xA5, 0x3C, 0xFF with `bs_valid` low for 3 cycles between words. Required:
  - Exactly 3 handshakes and 20 shifts.
  - `ccff_shift_en`=0 during the gaps.
  - Bits 4..7 of 0xFF never reach `ccff_head`.
- **Reset mid-load.** `pReset` after 3 shifts. Required:
  - Next cycle: all outputs are at reset values.
  - `start` is accepted afterwards and a fresh 6-bit load completes.
- **Start while busy.** Extra `start` pulses during LOAD have no effect; the shift count stays exactly CHAIN_LEN.
